// File: rtl/mcdt_pkt_fmt.sv
// Packet formatter: buffers arbiter words in a FIFO and frames them into
// header / payload / trailer packets, one source channel per packet.
module mcdt_pkt_fmt #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PKT_LEN    = 4,
  parameter int unsigned TIMEOUT    = 8
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [31:0] mcdt_data_i,
  input  logic        mcdt_val_i,
  input  logic [1:0]  mcdt_id_i,
  output logic [31:0] pkt_data_o,
  output logic        pkt_valid_o,
  input  logic        pkt_ready_i,
  output logic        pkt_sop_o,
  output logic        pkt_eop_o,
  output logic [5:0]  fifo_margin_o,
  output logic [15:0] drop_cnt_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 2;
  localparam int unsigned EW = IW + DW;
  localparam int unsigned LW = 3;
  localparam int unsigned TW = 8;
  localparam int unsigned SW = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_PAY  = 2'd2;
  localparam logic [1:0] ST_TRL  = 2'd3;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          drop;
  logic [IW-1:0] head_id;
  logic [DW-1:0] head_data;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] cur_id_q, cur_id_d;
  logic [SW-1:0] seq_q, seq_d;
  logic [LW-1:0] len_q, len_d;
  logic [TW-1:0] idle_q, idle_d;

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign head_id   = mem[rd_ptr][EW-1:DW];
  assign head_data = mem[rd_ptr][DW-1:0];

  // A full FIFO still accepts a word when the head leaves at the same edge.
  assign push = mcdt_val_i && (!full || pop);
  assign drop = mcdt_val_i && full && !pop;

  assign fifo_margin_o = 6'(FIFO_DEPTH) - 6'(count);

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= {mcdt_id_i, mcdt_data_i};
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      if (drop && (drop_cnt_o != 16'hFFFF)) begin
        drop_cnt_o <= drop_cnt_o + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= ST_IDLE;
      cur_id_q <= '0;
      seq_q    <= '0;
      len_q    <= '0;
      idle_q   <= '0;
    end else begin
      state_q  <= state_d;
      cur_id_q <= cur_id_d;
      seq_q    <= seq_d;
      len_q    <= len_d;
      idle_q   <= idle_d;
    end
  end

  // Next state and packet outputs; payload words are only offered for the packet's own channel.
  always_comb begin
    state_d     = state_q;
    cur_id_d    = cur_id_q;
    seq_d       = seq_q;
    len_d       = len_q;
    idle_d      = idle_q;
    pop         = 1'b0;
    pkt_valid_o = 1'b0;
    pkt_sop_o   = 1'b0;
    pkt_eop_o   = 1'b0;
    pkt_data_o  = '0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          state_d  = ST_HDR;
          cur_id_d = head_id;
          len_d    = '0;
          idle_d   = '0;
        end
      end
      ST_HDR: begin
        pkt_valid_o = 1'b1;
        pkt_sop_o   = 1'b1;
        pkt_data_o  = {8'hA5, 6'd0, cur_id_q, 8'd0, seq_q};
        if (pkt_ready_i) state_d = ST_PAY;
      end
      ST_PAY: begin
        if (!empty && (head_id == cur_id_q)) begin
          pkt_valid_o = 1'b1;
          pkt_data_o  = head_data;
          if (pkt_ready_i) begin
            pop    = 1'b1;
            len_d  = len_q + LW'(1);
            idle_d = '0;
            if ((len_q + LW'(1)) == LW'(PKT_LEN)) state_d = ST_TRL;
          end
        end else if (!empty) begin
          state_d = ST_TRL;
        end else begin
          idle_d = idle_q + TW'(1);
          if ((idle_q + TW'(1)) == TW'(TIMEOUT)) state_d = ST_TRL;
        end
      end
      ST_TRL: begin
        pkt_valid_o = 1'b1;
        pkt_eop_o   = 1'b1;
        pkt_data_o  = {8'h5A, 21'd0, len_q};
        if (pkt_ready_i) begin
          seq_d   = seq_q + SW'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mcdt_pkt_fmt.sv
// Self-checking bench for mcdt_pkt_fmt: queue-based packet model compared every
// cycle, plus directed scenarios with literal expected words.
module tb_mcdt_pkt_fmt;

  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned PKT_LEN    = 4;
  localparam int unsigned TIMEOUT    = 8;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [31:0] mcdt_data_i;
  logic        mcdt_val_i;
  logic [1:0]  mcdt_id_i;
  logic [31:0] pkt_data_o;
  logic        pkt_valid_o;
  logic        pkt_ready_i;
  logic        pkt_sop_o;
  logic        pkt_eop_o;
  logic [5:0]  fifo_margin_o;
  logic [15:0] drop_cnt_o;

  always #5 clk_i = ~clk_i;

  mcdt_pkt_fmt #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .PKT_LEN   (PKT_LEN),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .mcdt_data_i  (mcdt_data_i),
    .mcdt_val_i   (mcdt_val_i),
    .mcdt_id_i    (mcdt_id_i),
    .pkt_data_o   (pkt_data_o),
    .pkt_valid_o  (pkt_valid_o),
    .pkt_ready_i  (pkt_ready_i),
    .pkt_sop_o    (pkt_sop_o),
    .pkt_eop_o    (pkt_eop_o),
    .fifo_margin_o(fifo_margin_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int eop_cnt  = 0;

  // Model: FIFO as a queue of {id,data}; phase 0=waiting 1=header 2=payload 3=trailer.
  logic [33:0] mq[$];
  int          m_ph;
  logic [1:0]  m_id;
  logic [7:0]  m_seq;
  int          m_len;
  int          m_idle;
  int          m_drop;

  // Accepted transfers as {sop,eop,data}, with the cycle they were taken in.
  logic [33:0] lg[$];
  int          lgc[$];
  logic [33:0] hdrs[$];
  logic [33:0] exp036 [6];
  logic [33:0] exp037 [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_log(input string nm, input int idx, input logic [33:0] exp);
    if (idx < lg.size()) begin
      chk(nm, 64'(lg[idx]), 64'(exp));
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: actual <no transfer> required %0h", nm, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ph   = 0;
    m_id   = 2'd0;
    m_seq  = 8'd0;
    m_len  = 0;
    m_idle = 0;
    m_drop = 0;
  endtask

  function automatic bit e_valid();
    return (m_ph == 1) || (m_ph == 3) ||
           ((m_ph == 2) && (mq.size() != 0) && (mq[0][33:32] == m_id));
  endfunction

  function automatic logic [33:0] e_word();
    if (m_ph == 1) return {2'b10, 8'hA5, 6'd0, m_id, 8'd0, m_seq};
    if (m_ph == 3) return {2'b01, 8'h5A, 21'd0, 3'(m_len)};
    return {2'b00, mq[0][31:0]};
  endfunction

  // Advance the model across one rising edge using the inputs the DUT will see.
  task automatic model_step();
    bit xfer, do_pop, do_push;
    if (!rstn_i) begin
      model_reset();
      return;
    end
    xfer    = e_valid() && pkt_ready_i;
    do_pop  = (m_ph == 2) && xfer;
    do_push = mcdt_val_i && ((mq.size() < int'(FIFO_DEPTH)) || do_pop);
    if (mcdt_val_i && !do_push && (m_drop < 65535)) m_drop++;
    case (m_ph)
      0: if (mq.size() != 0) begin
        m_ph = 1; m_id = mq[0][33:32]; m_len = 0; m_idle = 0;
      end
      1: if (xfer) m_ph = 2;
      2: begin
        if (do_pop) begin
          m_len++;
          m_idle = 0;
          if (m_len == int'(PKT_LEN)) m_ph = 3;
        end else if (mq.size() != 0) begin
          if (mq[0][33:32] != m_id) m_ph = 3;
        end else begin
          m_idle++;
          if (m_idle == int'(TIMEOUT)) m_ph = 3;
        end
      end
      default: if (xfer) begin m_seq++; m_ph = 0; end
    endcase
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back({mcdt_id_i, mcdt_data_i});
  endtask

  // One clock: log the transfer about to happen, step the model, compare at the falling edge.
  task automatic tick();
    bit          held;
    logic [33:0] held_word;
    held      = rstn_i && pkt_valid_o && !pkt_ready_i;
    held_word = {pkt_sop_o, pkt_eop_o, pkt_data_o};
    if (rstn_i && pkt_valid_o && pkt_ready_i) begin
      lg.push_back({pkt_sop_o, pkt_eop_o, pkt_data_o});
      lgc.push_back(cyc);
      if (pkt_eop_o) eop_cnt++;
    end
    model_step();
    @(negedge clk_i);
    cyc++;
    if (held && rstn_i) chk("hold", 64'({pkt_sop_o, pkt_eop_o, pkt_data_o}), 64'(held_word));
    chk("valid", 64'(pkt_valid_o), 64'(e_valid()));
    if (e_valid()) chk("word", 64'({pkt_sop_o, pkt_eop_o, pkt_data_o}), 64'(e_word()));
    chk("margin", 64'(fifo_margin_o), 64'(FIFO_DEPTH - mq.size()));
    chk("drop", 64'(drop_cnt_o), 64'(m_drop));
  endtask

  task automatic send(input logic [1:0] id, input logic [31:0] data);
    mcdt_val_i  = 1'b1;
    mcdt_id_i   = id;
    mcdt_data_i = data;
    tick();
    mcdt_val_i  = 1'b0;
  endtask

  task automatic wait_eops(input int target, input int budget, input string nm);
    int b = 0;
    while ((eop_cnt < target) && (b < budget)) begin
      tick();
      b++;
    end
    if (eop_cnt < target) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: actual %0d trailers required %0d within %0d cycles", nm, eop_cnt, target, budget);
    end
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    tick();
    tick();
    rstn_i = 1'b1;
  endtask

  initial begin
    int b;
    int e0;
    int rp;
    rstn_i      = 1'b0;
    mcdt_val_i  = 1'b0;
    mcdt_id_i   = 2'd0;
    mcdt_data_i = 32'd0;
    pkt_ready_i = 1'b0;
    model_reset();

    // Reset state
    tick();
    chk("rst_valid", 64'(pkt_valid_o), 64'd0);
    chk("rst_data", 64'(pkt_data_o), 64'd0);
    chk("rst_margin", 64'(fifo_margin_o), 64'd16);
    chk("rst_drop", 64'(drop_cnt_o), 64'd0);
    rstn_i = 1'b1;
    tick();

    // Four channel-0 words, ready held high
    do_reset();
    pkt_ready_i = 1'b1;
    b  = lg.size();
    e0 = eop_cnt;
    for (int i = 0; i < 4; i++) send(2'd0, 32'h00C0_0000 + 32'(i));
    wait_eops(e0 + 1, 40, "t036_wait");
    exp036 = '{{2'b10, 32'hA500_0000}, {2'b00, 32'h00C0_0000}, {2'b00, 32'h00C0_0001},
               {2'b00, 32'h00C0_0002}, {2'b00, 32'h00C0_0003}, {2'b01, 32'h5A00_0004}};
    for (int k = 0; k < 6; k++) chk_log($sformatf("t036_w%0d", k), b + k, exp036[k]);
    send(2'd0, 32'h0000_1234);
    wait_eops(e0 + 2, 40, "t036_wait2");
    chk_log("t036_seq1", b + 6, {2'b10, 32'hA500_0001});

    // Channel switch closes a one-word packet
    do_reset();
    b  = lg.size();
    e0 = eop_cnt;
    send(2'd1, 32'h00C1_0000);
    send(2'd2, 32'h00C2_0000);
    wait_eops(e0 + 2, 60, "t037_wait");
    exp037 = '{{2'b10, 32'hA501_0000}, {2'b00, 32'h00C1_0000}, {2'b01, 32'h5A00_0001},
               {2'b10, 32'hA502_0001}, {2'b00, 32'h00C2_0000}, {2'b01, 32'h5A00_0001}};
    for (int k = 0; k < 6; k++) chk_log($sformatf("t037_w%0d", k), b + k, exp037[k]);

    // Timeout closes a packet; trailer shows up TIMEOUT edges after the payload transfer edge
    do_reset();
    b  = lg.size();
    e0 = eop_cnt;
    send(2'd0, 32'h00C0_00AA);
    wait_eops(e0 + 1, 40, "t038_wait");
    chk_log("t038_trl", b + 2, {2'b01, 32'h5A00_0001});
    if (lgc.size() > b + 2) chk("t038_gap", 64'(lgc[b + 2] - lgc[b + 1]), 64'(TIMEOUT + 1));

    // Overflow with the consumer stalled
    do_reset();
    pkt_ready_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      mcdt_val_i  = 1'b1;
      mcdt_id_i   = 2'd0;
      mcdt_data_i = 32'h00E0_0000 + 32'(i);
      tick();
    end
    mcdt_val_i = 1'b0;
    tick();
    chk("t039_margin", 64'(fifo_margin_o), 64'd0);
    chk("t039_drop", 64'(drop_cnt_o), 64'd4);
    chk("t039_hdr", 64'({pkt_valid_o, pkt_sop_o, pkt_eop_o, pkt_data_o}), 64'({3'b110, 32'hA500_0000}));
    repeat (5) tick();
    chk("t039_hdr_held", 64'({pkt_valid_o, pkt_sop_o, pkt_eop_o, pkt_data_o}), 64'({3'b110, 32'hA500_0000}));
    e0 = eop_cnt;
    pkt_ready_i = 1'b1;
    wait_eops(e0 + 4, 100, "t039_drain");

    // Reset in the middle of a payload
    do_reset();
    for (int i = 0; i < 3; i++) send(2'd0, 32'h00B0_0000 + 32'(i));
    for (int i = 0; (i < 20) && !(pkt_valid_o && !pkt_sop_o && !pkt_eop_o); i++) tick();
    chk("t040_in_pay", 64'({pkt_valid_o, pkt_sop_o, pkt_eop_o}), 64'(3'b100));
    rstn_i = 1'b0;
    model_reset();
    #1;
    chk("t040_valid", 64'({pkt_valid_o, pkt_sop_o, pkt_eop_o}), 64'd0);
    chk("t040_data", 64'(pkt_data_o), 64'd0);
    chk("t040_margin", 64'(fifo_margin_o), 64'd16);
    tick();
    rstn_i = 1'b1;
    b  = lg.size();
    e0 = eop_cnt;
    send(2'd0, 32'h00D0_0000);
    wait_eops(e0 + 1, 40, "t040_wait");
    chk_log("t040_hdr", b, {2'b10, 32'hA500_0000});
    chk_log("t040_pay", b + 1, {2'b00, 32'h00D0_0000});
    chk_log("t040_trl", b + 2, {2'b01, 32'h5A00_0001});

    // 257 single-word packets: sequence number wraps in the header
    do_reset();
    b = lg.size();
    for (int p = 0; p < 257; p++) begin
      e0 = eop_cnt;
      send(2'd0, 32'(p));
      wait_eops(e0 + 1, 40, "t041_wait");
    end
    for (int k = b; k < lg.size(); k++) if (lg[k][33]) hdrs.push_back(lg[k]);
    chk("t041_count", 64'(hdrs.size()), 64'd257);
    if (hdrs.size() == 257) begin
      chk("t041_h0", 64'(hdrs[0]), 64'({2'b10, 32'hA500_0000}));
      chk("t041_h1", 64'(hdrs[1]), 64'({2'b10, 32'hA500_0001}));
      chk("t041_h255", 64'(hdrs[255]), 64'({2'b10, 32'hA500_00FF}));
      chk("t041_h256", 64'(hdrs[256]), 64'({2'b10, 32'hA500_0000}));
    end

    // Random traffic on all channels with varying consumer throughput
    do_reset();
    rp = 100;
    for (int i = 0; i < 4000; i++) begin
      if ((i % 250) == 0) begin
        case ($urandom_range(0, 3))
          0: rp = 10;
          1: rp = 50;
          2: rp = 90;
          default: rp = 100;
        endcase
      end
      pkt_ready_i = ($urandom_range(0, 99) < rp);
      mcdt_val_i  = ($urandom_range(0, 99) < 45);
      mcdt_id_i   = 2'($urandom_range(0, 2));
      mcdt_data_i = $urandom;
      tick();
    end
    mcdt_val_i  = 1'b0;
    pkt_ready_i = 1'b1;
    repeat (200) tick();
    chk("drain_margin", 64'(fifo_margin_o), 64'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
